// File: rtl/cc_seq_alu.sv
// cc_seq_alu: multi-cycle ALU with start/busy/done handshake and registered
// N/Z/V/C condition codes.
//   Logic/add/sub/pass : EXEC state, done two edges after acceptance.
//   SLL/SRL/SRA        : one bit per cycle, k = B[SHAMT_W-1:0].
//   MULCC              : iterative shift-add, low half of the product.
// Optional feature macro: CC_SEQALU_MUL_EN. When it is undefined, no multiplier
// exists and opcode 8 behaves as a flag-writing pass of A.
// Ports:
//   CC_SEQALU_CLOCK_50          clock, rising edge
//   CC_SEQALU_RESET_InLow       synchronous active-low reset
//   CC_SEQALU_Start_InHigh      request, sampled only when idle
//   CC_SEQALU_Selection_In      opcode
//   CC_SEQALU_DataBUSA_In/B_In  operands (B also carries the shift amount)
//   CC_SEQALU_Busy_OutHigh      operation in progress
//   CC_SEQALU_Done_OutHigh      one-cycle completion pulse
//   CC_SEQALU_DataBUS_Out       registered result
//   CC_SEQALU_*_OutHigh flags   registered N/Z/V/C
module cc_seq_alu #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int SHAMT_W                 = $clog2(DATAWIDTH_BUS)
) (
  input  logic                               CC_SEQALU_CLOCK_50,
  input  logic                               CC_SEQALU_RESET_InLow,
  input  logic                               CC_SEQALU_Start_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_SEQALU_Selection_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_SEQALU_DataBUSA_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_SEQALU_DataBUSB_In,
  output logic                               CC_SEQALU_Busy_OutHigh,
  output logic                               CC_SEQALU_Done_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]           CC_SEQALU_DataBUS_Out,
  output logic                               CC_SEQALU_Negative_OutHigh,
  output logic                               CC_SEQALU_Zero_OutHigh,
  output logic                               CC_SEQALU_Overflow_OutHigh,
  output logic                               CC_SEQALU_Carry_OutHigh
);
  localparam int W  = DATAWIDTH_BUS;
  localparam int SW = DATAWIDTH_ALU_SELECTION;
`ifdef CC_SEQALU_MUL_EN
  localparam int ACC_W = 2 * W;
`else
  localparam int ACC_W = W;
`endif

  localparam logic [SW-1:0] OP_AND = SW'(0);
  localparam logic [SW-1:0] OP_OR  = SW'(1);
  localparam logic [SW-1:0] OP_NOR = SW'(2);
  localparam logic [SW-1:0] OP_ADD = SW'(3);
  localparam logic [SW-1:0] OP_SUB = SW'(4);
  localparam logic [SW-1:0] OP_SLL = SW'(5);
  localparam logic [SW-1:0] OP_SRL = SW'(6);
  localparam logic [SW-1:0] OP_SRA = SW'(7);
  localparam logic [SW-1:0] OP_MUL = SW'(8);

  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MUL, DONE} state_t;

  state_t             state, nextState;
  logic [SW-1:0]      opLat;
  logic [W-1:0]       aLat, bLat;
  logic               flagWr;
  logic [ACC_W-1:0]   acc;
  logic [SHAMT_W:0]   cnt;
  logic               vStage, cStage;

  logic               accept, isShift, isMul, isFlagOp;
  logic [W-1:0]       execRes, shiftRes;
  logic               execV, execC;
  logic [W:0]         sumExt, diffExt;

  // busy stays high through the done cycle; blocking acceptance on it keeps a
  // start held across the done pulse from being taken until the next idle cycle.
  assign accept  = (state == IDLE) && !CC_SEQALU_Busy_OutHigh && CC_SEQALU_Start_InHigh;
  assign isShift = (CC_SEQALU_Selection_In == OP_SLL) || (CC_SEQALU_Selection_In == OP_SRL) ||
                   (CC_SEQALU_Selection_In == OP_SRA);
`ifdef CC_SEQALU_MUL_EN
  assign isMul   = (CC_SEQALU_Selection_In == OP_MUL);
`else
  assign isMul   = 1'b0;
`endif
  assign isFlagOp = (CC_SEQALU_Selection_In <= OP_SUB) || (CC_SEQALU_Selection_In == OP_MUL);

  assign sumExt  = {1'b0, aLat} + {1'b0, bLat};
  assign diffExt = {1'b0, aLat} - {1'b0, bLat};

  always_comb begin
    execRes = aLat;
    execV   = 1'b0;
    execC   = 1'b0;
    case (opLat)
      OP_AND: execRes = aLat & bLat;
      OP_OR:  execRes = aLat | bLat;
      OP_NOR: execRes = ~(aLat | bLat);
      OP_ADD: begin
        execRes = sumExt[W-1:0];
        execC   = sumExt[W];
        execV   = (aLat[W-1] == bLat[W-1]) && (sumExt[W-1] != aLat[W-1]);
      end
      OP_SUB: begin
        execRes = diffExt[W-1:0];
        execC   = diffExt[W];  // borrow out == (A <u B)
        execV   = (aLat[W-1] != bLat[W-1]) && (diffExt[W-1] != aLat[W-1]);
      end
      default: ;
    endcase
  end

  always_comb begin
    shiftRes = {acc[W-1], acc[W-1:1]};
    if (opLat == OP_SLL)      shiftRes = {acc[W-2:0], 1'b0};
    else if (opLat == OP_SRL) shiftRes = {1'b0, acc[W-1:1]};
  end

`ifdef CC_SEQALU_MUL_EN
  // Upper half accumulates A when the multiplier LSB (acc[0]) is set, then the
  // whole {carry, upper, lower} shifts right; after W steps acc holds A*B.
  logic [W:0] mulSum;
  assign mulSum = {1'b0, acc[ACC_W-1:W]} + (acc[0] ? {1'b0, aLat} : {(W+1){1'b0}});
`endif

  always_ff @(posedge CC_SEQALU_CLOCK_50) begin
    if (!CC_SEQALU_RESET_InLow) state <= IDLE;
    else                        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (accept) begin
               if (isShift)    nextState = SHIFT;
               else if (isMul) nextState = MUL;
               else            nextState = EXEC;
             end
      EXEC:  nextState = DONE;
      SHIFT: if (cnt == '0) nextState = DONE;
      MUL:   if (cnt == '0) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CC_SEQALU_CLOCK_50) begin
    if (!CC_SEQALU_RESET_InLow) begin
      opLat  <= '0;
      aLat   <= '0;
      bLat   <= '0;
      flagWr <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      vStage <= 1'b0;
      cStage <= 1'b0;
      CC_SEQALU_Busy_OutHigh     <= 1'b0;
      CC_SEQALU_Done_OutHigh     <= 1'b0;
      CC_SEQALU_DataBUS_Out      <= '0;
      CC_SEQALU_Negative_OutHigh <= 1'b0;
      CC_SEQALU_Zero_OutHigh     <= 1'b0;
      CC_SEQALU_Overflow_OutHigh <= 1'b0;
      CC_SEQALU_Carry_OutHigh    <= 1'b0;
    end else begin
      CC_SEQALU_Busy_OutHigh <= (state != IDLE);
      CC_SEQALU_Done_OutHigh <= (state == DONE);
      case (state)
        IDLE: if (accept) begin
          opLat  <= CC_SEQALU_Selection_In;
          aLat   <= CC_SEQALU_DataBUSA_In;
          bLat   <= CC_SEQALU_DataBUSB_In;
          flagWr <= isFlagOp;
          if (isMul) begin
            cnt <= (SHAMT_W+1)'(W);
            acc <= ACC_W'(CC_SEQALU_DataBUSB_In);
          end else begin
            cnt <= {1'b0, CC_SEQALU_DataBUSB_In[SHAMT_W-1:0]};
            acc <= ACC_W'(CC_SEQALU_DataBUSA_In);
          end
        end
        EXEC: begin
          acc    <= ACC_W'(execRes);
          vStage <= execV;
          cStage <= execC;
        end
        SHIFT: if (cnt != '0) begin
          acc <= ACC_W'(shiftRes);
          cnt <= cnt - 1'b1;
        end
`ifdef CC_SEQALU_MUL_EN
        MUL: if (cnt != '0) begin
          acc <= {mulSum, acc[W-1:1]};
          cnt <= cnt - 1'b1;
        end
`endif
        DONE: begin
          CC_SEQALU_DataBUS_Out <= acc[W-1:0];
          if (flagWr) begin
            CC_SEQALU_Negative_OutHigh <= acc[W-1];
            CC_SEQALU_Zero_OutHigh     <= (acc[W-1:0] == '0);
`ifdef CC_SEQALU_MUL_EN
            if (opLat == OP_MUL) begin
              CC_SEQALU_Overflow_OutHigh <= |acc[ACC_W-1:W];
              CC_SEQALU_Carry_OutHigh    <= |acc[ACC_W-1:W];
            end else begin
              CC_SEQALU_Overflow_OutHigh <= vStage;
              CC_SEQALU_Carry_OutHigh    <= cStage;
            end
`else
            CC_SEQALU_Overflow_OutHigh <= vStage;
            CC_SEQALU_Carry_OutHigh    <= cStage;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cc_seq_alu.sv
// Scoreboard bench for cc_seq_alu (default 32-bit build). Expected results,
// flags and done latency are pushed when a start is driven and checked when
// done pulses.
module tb_cc_seq_alu;
  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [3:0]  sel;
  logic [31:0] busA, busB;
  logic        busy, done, fN, fZ, fV, fC;
  logic [31:0] res;

  cc_seq_alu dut (
    .CC_SEQALU_CLOCK_50         (clk),
    .CC_SEQALU_RESET_InLow      (rstN),
    .CC_SEQALU_Start_InHigh     (start),
    .CC_SEQALU_Selection_In     (sel),
    .CC_SEQALU_DataBUSA_In      (busA),
    .CC_SEQALU_DataBUSB_In      (busB),
    .CC_SEQALU_Busy_OutHigh     (busy),
    .CC_SEQALU_Done_OutHigh     (done),
    .CC_SEQALU_DataBUS_Out      (res),
    .CC_SEQALU_Negative_OutHigh (fN),
    .CC_SEQALU_Zero_OutHigh     (fZ),
    .CC_SEQALU_Overflow_OutHigh (fV),
    .CC_SEQALU_Carry_OutHigh    (fC)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        n, z, v, c;
    int          t0;
    int          lat;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   nChk = 0;
  int   nFail = 0;
  logic eN = 0, eZ = 0, eV = 0, eC = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: plain operators on wide integers.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input int t0, output exp_t e);
    logic [63:0] wide;
    longint      sv;
    logic        wf, v, c;
    logic [31:0] r;
    int          k;
    k  = int'(b[4:0]);
    wf = 1'b1; v = 1'b0; c = 1'b0; r = a;
    e.lat = 2;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a | b);
      4'd3: begin
        wide = {32'b0, a} + {32'b0, b};
        r = wide[31:0]; c = wide[32];
        sv = longint'($signed(a)) + longint'($signed(b));
        v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd4: begin
        r = a - b; c = (a < b);
        sv = longint'($signed(a)) - longint'($signed(b));
        v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd5: begin r = a << k; wf = 1'b0; e.lat = 2 + k; end
      4'd6: begin r = a >> k; wf = 1'b0; e.lat = 2 + k; end
      4'd7: begin r = $signed(a) >>> k; wf = 1'b0; e.lat = 2 + k; end
`ifdef CC_SEQALU_MUL_EN
      4'd8: begin
        wide = {32'b0, a} * {32'b0, b};
        r = wide[31:0]; v = (wide[63:32] != 0); c = v; e.lat = 34;
      end
`else
      4'd8: r = a;
`endif
      default: begin r = a; wf = 1'b0; end
    endcase
    if (wf) begin eN = r[31]; eZ = (r == 0); eV = v; eC = c; end
    e.res = r; e.n = eN; e.z = eZ; e.v = eV; e.c = eC;
    e.t0 = t0; e.tag = tag;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) chk("spuriousDone", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".res"}, res, e.res);
        chk({e.tag, ".N"}, fN, e.n);
        chk({e.tag, ".Z"}, fZ, e.z);
        chk({e.tag, ".V"}, fV, e.v);
        chk({e.tag, ".C"}, fC, e.c);
        chk({e.tag, ".lat"}, cyc - e.t0, e.lat);
        chk({e.tag, ".busyAtDone"}, busy, 1);
      end
    end
  end

  // hold: edges the start stays high before acceptance is expected.
  // glitch: pulse a foreign start while the op runs (must be ignored).
  task automatic doOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag, input int hold = 1, input bit waitFirst = 1,
                      input bit glitch = 0);
    exp_t e;
    int   n;
    if (waitFirst) @(negedge clk);
    sel = op; busA = a; busB = b; start = 1'b1;
    model(op, a, b, tag, cyc + hold, e);
    q.push_back(e);
    repeat (hold) @(negedge clk);
    start = 1'b0;
    busA = ~a; busB = ~b; sel = ~op;   // latched values must be used
    @(negedge clk);
    chk({tag, ".busy"}, busy, 1);
    if (glitch) begin
      @(negedge clk);
      start = 1'b1; sel = 4'd3; busA = 32'd5; busB = 32'd6;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, ".doneSeen"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstN = 1'b0; start = 1'b0; sel = 4'd0; busA = 32'd0; busB = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.res", res, 0);
    chk("rst.flags", {fN, fZ, fV, fC}, 4'b0000);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    rstN = 1'b1;

    doOp(4'd3, 32'h7FFF_FFFF, 32'd1, "addOvf");
    doOp(4'd4, 32'd1, 32'd2, "subBorrow");
    doOp(4'd5, 32'd1, 32'd31, "sll31");
    doOp(4'd7, 32'h8000_0000, 32'h24, "sraK4", 1, 1, 1);
    doOp(4'd8, 32'h1_0000, 32'h1_0000, "mulWrap");
    doOp(4'd13, 32'h1234, 32'hFFFF, "rsv13");
    doOp(4'd0, 32'hF0F0_1234, 32'h0F0F_4321, "and");
    doOp(4'd2, 32'hFFFF_0000, 32'h0000_FFFF, "norZero");
    doOp(4'd6, 32'h8000_0000, 32'hFFFF_FFE0, "srlK0");
    doOp(4'd3, 32'hFFFF_FFFF, 32'd1, "addCarry");
    // Start raised during the done cycle: taken one idle cycle later.
    doOp(4'd1, 32'h00A0, 32'h0005, "orB2b", 2, 0);
    doOp(4'd8, 32'd7, 32'd9, "mulSmall");

    // Reset mid-operation: aborted, no done, outputs cleared.
    @(negedge clk);
`ifdef CC_SEQALU_MUL_EN
    sel = 4'd8; busB = 32'd5;
`else
    sel = 4'd5; busB = 32'd20;
`endif
    busA = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    chk("abort.res", res, 0);
    chk("abort.flags", {fN, fZ, fV, fC}, 4'b0000);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    eN = 0; eZ = 0; eV = 0; eC = 0;
    doOp(4'd9, 32'hCAFE_0001, 32'd0, "afterRst", 1, 0);
    repeat (40) @(negedge clk);   // a late done from the aborted op would be spurious

    for (int i = 0; i < 10; i++)
      doOp(4'($urandom_range(0, 15)), $urandom, $urandom, $sformatf("rnd%0d", i));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/cc_seq_alu.md
# cc_seq_alu

Parametrised multi-cycle ALU for the microdatapath. It accepts an operation through a start/busy/done handshake and executes logic, add and subtract in one cycle. Variable-amount shifts run one bit per cycle, and multiply runs as an iterative shift-add. Result and N/Z/V/C flags are registered, so the control unit can read them directly as condition codes.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, operand/result width (≥4, power of two)
- DATAWIDTH_ALU_SELECTION, 4, opcode width (fixed at 4 for the opcode map below)
- SHAMT_W, $clog2(DATAWIDTH_BUS), shift-amount width taken from B

Ports:
- CC_SEQALU_CLOCK_50  in  1  system clock, all state on rising edge
- CC_SEQALU_RESET_InLow  in  1  synchronous, active-low reset
- CC_SEQALU_Start_InHigh  in  1  request; sampled only in IDLE
- CC_SEQALU_Selection_In  in  DATAWIDTH_ALU_SELECTION  opcode
- CC_SEQALU_DataBUSA_In  in  DATAWIDTH_BUS  operand A
- CC_SEQALU_DataBUSB_In  in  DATAWIDTH_BUS  operand B / shift amount
- CC_SEQALU_Busy_OutHigh  out  1  operation in progress
- CC_SEQALU_Done_OutHigh  out  1  one-cycle pulse, result valid
- CC_SEQALU_DataBUS_Out  out  DATAWIDTH_BUS  registered result
- CC_SEQALU_Negative_OutHigh, _Zero_OutHigh, _Overflow_OutHigh, _Carry_OutHigh  out  1 each  registered flags

## Operation
- Opcodes:
  - 0 ANDCC
  - 1 ORCC
  - 2 NORCC
  - 3 ADDCC
  - 4 SUBCC (A−B)
  - 5 SLL
  - 6 SRL
  - 7 SRA
  - 8 MULCC (unsigned, low half)
  - 9 PASSA
  - 10–15 reserved: behave as PASSA.
- Operands and opcode are latched when a start is accepted. After acceptance, input changes have no effect.
- Flag update rule: only opcodes 0,1,2,3,4,8 write the flags. All other opcodes leave the flags unchanged.
- Flag values:
  - N = result MSB.
  - Z = (result == 0).
  - ADDCC: C = carry out, V = signed overflow.
  - SUBCC: C = borrow (A <u B), V = signed overflow of A−B.
  - Logic ops: V = C = 0.
  - MULCC: C = V = (upper DATAWIDTH_BUS bits of the full product ≠ 0).
- Shift amount k = B[SHAMT_W-1:0]. The upper bits of B are ignored.
- States:
  - IDLE: on start, latch inputs and go to EXEC, SHIFT or MUL depending on the opcode.
  - EXEC: compute, write result and flags, go to DONE.
  - SHIFT: shift 1 bit per cycle while the counter is nonzero. When the counter reaches 0, go to DONE.
  - MUL: one shift-add step per cycle for DATAWIDTH_BUS cycles, then go to DONE.
  - DONE: pulse done, return to IDLE.
- SRA replicates the MSB. SRL and SLL fill with 0.

## Timing
- Reset (RESET_InLow=0 at a clock edge):
  - State goes to IDLE; result, all flags, busy and done go to 0.
  - Reset mid-operation aborts the operation with no done pulse.
- A start is accepted at edge T0 when the block is in IDLE with start=1. Busy=1 from T0+1 until the done cycle, inclusive.
- Done latency, measured from T0 (done is high in the cycle after the edge listed):
  - EXEC ops: done at T0+2.
  - Shifts: done at T0+2+k (k=0 gives T0+2).
  - MUL: done at T0+2+DATAWIDTH_BUS.
- Result and flags update on the same edge that raises done. They are held until the next completion.
- Start while busy is ignored; no queueing takes place.
- Start may be asserted in the DONE cycle. It is taken at the next IDLE cycle only if it is still high.
- Arithmetic is performed at DATAWIDTH_BUS+1 bits internally. The MUL accumulator is 2×DATAWIDTH_BUS bits.

## Configuration
- CC_SEQALU_MUL_EN defined: MUL state, counter and accumulator are compiled in, and opcode 8 behaves as described above.
- CC_SEQALU_MUL_EN undefined: no multiplier logic exists. Opcode 8 goes to EXEC, returns A, and sets flags as for a logic op (N, Z from A; V = C = 0). Done latency is T0+2.

## Test plan
- Reset mid-MUL (assert reset at T0+5 with A=3, B=5) -> outputs all 0, no done pulse, block accepts a new start next cycle.
- ADDCC A=0x7FFFFFFF, B=1 -> result 0x80000000, N=1, Z=0, V=1, C=0, done at T0+2.
- SUBCC A=1, B=2 -> result 0xFFFFFFFF, N=1, C=1, V=0. Then SLL A=1, B=31 -> result 0x80000000, done at T0+33, flags unchanged from the SUBCC.
- SRA A=0x80000000, B=0x24 (k=4) -> result 0xF8000000, done at T0+6. Start pulsed at T0+3 is ignored.
- MULCC (macro on) A=0x10000, B=0x10000 -> result 0, Z=1, C=V=1, done at T0+34. With the macro off, the same stimulus gives result 0x10000, C=V=0, done at T0+2.
- Reserved opcode 13, A=0x1234 -> result 0x1234, flags retained from the previous op, done at T0+2.
